// File: rtl/tile_palette_bank.sv
// Multi-bank runtime-writable colour palette with transparency flag and global fade scale.
// Latency: 2 cycles from accepted rd_valid to out_valid; writes visible the cycle after acceptance.
// Backpressure: none on reads; wr_ready low while the post-reset clear runs, high in RUN.
module tile_palette_bank #(
    parameter int INDEX_W         = 4,
    parameter int CH_W            = 4,
    parameter int NUM_BANKS       = 4,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
    input  logic [INDEX_W-1:0]           wr_index,
    input  logic [3*CH_W-1:0]            wr_color,
    input  logic                         rd_valid,
    input  logic [$clog2(NUM_BANKS)-1:0] rd_bank,
    input  logic [INDEX_W-1:0]           rd_index,
    input  logic [CH_W-1:0]              fade_level,
    output logic                         init_done,
    output logic                         out_valid,
    output logic                         out_transparent,
    output logic [CH_W-1:0]              red,
    output logic [CH_W-1:0]              green,
    output logic [CH_W-1:0]              blue
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ADDR_W = BANK_W + INDEX_W;
    localparam int DEPTH  = NUM_BANKS << INDEX_W;
    localparam int WORD_W = 3 * CH_W;
    localparam int PW     = 2 * CH_W + 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   init_cnt;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                s1_vld;
    logic [WORD_W-1:0]   s1_word;
    logic                s1_transp;
    logic [CH_W-1:0]     s1_fade;

    logic [CH_W-1:0]     fade_r;
    logic [CH_W-1:0]     fade_g;
    logic [CH_W-1:0]     fade_b;

    // Scale one channel by (fade+1)/2^CH_W; full-width product so 15*16 cannot wrap.
    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [CH_W-1:0] f);
        logic [PW-1:0] f_p1;
        logic [PW-1:0] prod;
        f_p1 = PW'(f) + PW'(1);
        prod = PW'(c) * f_p1;
        return prod[2*CH_W-1:CH_W];
    endfunction

    // Clear sequencer: walk every entry once after reset, then enable writes and reads.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + ADDR_W'(1);
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                        wr_ready  <= 1'b1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                    wr_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Palette storage: zero-fill during INIT, host writes in RUN; no async reset on contents.
    always_ff @(posedge Clk) begin
        if (state == S_INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_valid && wr_ready) begin
            mem[{wr_bank, wr_index}] <= wr_color;
        end
    end

    // Stage 1: fetch entry (old value on same-cycle write), transparency and fade snapshot.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld    <= 1'b0;
            s1_word   <= '0;
            s1_transp <= 1'b0;
            s1_fade   <= '0;
        end else begin
            s1_vld    <= rd_valid && (state == S_RUN);
            s1_word   <= mem[{rd_bank, rd_index}];
            s1_transp <= (rd_index == INDEX_W'(TRANSPARENT_IDX));
            s1_fade   <= fade_level;
        end
    end

    // Per-channel fade of the stage-1 word.
    always_comb begin
        fade_r = scale(s1_word[3*CH_W-1:2*CH_W], s1_fade);
        fade_g = scale(s1_word[2*CH_W-1:CH_W],   s1_fade);
        fade_b = scale(s1_word[CH_W-1:0],        s1_fade);
    end

    // Stage 2: register faded colour; data holds its last value when no lookup arrives.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid       <= 1'b0;
            out_transparent <= 1'b0;
            red             <= '0;
            green           <= '0;
            blue            <= '0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_transparent <= s1_transp;
                red             <= fade_r;
                green           <= fade_g;
                blue            <= fade_b;
            end
        end
    end

endmodule

// File: doc/tile_palette_bank.md
Name: tile_palette_bank

Overview:
Runtime-writable, multi-bank colour palette for the tile and sprite renderers. It replaces fixed 16-entry lookup tables with NUM_BANKS banks of 2^INDEX_W entries, all loadable by the game controller. A 2-stage registered read pipeline produces RGB output with per-pixel transparency detection and a global fade (brightness) scale. It sits between the pixel-index generators and the VGA colour mux.

Parameters:
INDEX_W, 4, width of colour index; entries per bank = 2^INDEX_W
CH_W, 4, bits per colour channel (R, G, B)
NUM_BANKS, 4, number of independent palettes; must be a power of two, >= 2
TRANSPARENT_IDX, 0, index flagged as transparent in every bank

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_bank  in  log2(NUM_BANKS)  target bank
wr_index  in  INDEX_W  target entry
wr_color  in  3*CH_W  {R,G,B}
rd_valid  in  1  pixel lookup request
rd_bank  in  log2(NUM_BANKS)  bank for lookup
rd_index  in  INDEX_W  colour index
fade_level  in  CH_W  brightness; all-ones = full, 0 = black
init_done  out  1  high once post-reset clear completes
out_valid  out  1  RGB valid, 2 cycles after the accepted rd_valid
out_transparent  out  1  rd_index == TRANSPARENT_IDX
red, green, blue  out  CH_W each  faded colour

Behaviour:
- Storage: NUM_BANKS*2^INDEX_W words of 3*CH_W bits, registers or inferred RAM, indexed {bank,index}.
- Reset (Reset_n low, async): FSM -> INIT; init counter = 0; init_done, wr_ready, out_valid, out_transparent, red, green, blue all 0; pipeline valid bits cleared. Memory contents are not reset asynchronously.
- INIT state: one entry written to 0 per cycle, counter 0 .. NUM_BANKS*2^INDEX_W-1. On the last write -> RUN next cycle. init_done = 1 and wr_ready = 1 from the first RUN cycle. Default geometry takes 64 cycles.
- During INIT: rd_valid is ignored (out_valid stays 0); wr_valid is not accepted.
- RUN state: wr_ready held 1. An accepted write updates the entry at the clock edge.
- Reset_n asserted mid-INIT or mid-RUN: returns to INIT immediately and restarts the clear from entry 0. In-flight reads are dropped.
- Read pipeline, fully pipelined, one lookup per cycle, no backpressure.
  - Stage 1 (edge after request): registers the entry word, the transparency flag (rd_index == TRANSPARENT_IDX) and fade_level sampled in the request cycle. Valid bit = rd_valid && RUN.
  - Stage 2 (next edge): each channel out = (c * (fade_level + 1)) >> CH_W. Compute the product at 2*CH_W+1 bits with no overflow, then truncate to CH_W. out_valid, out_transparent and the RGB outputs register together.
- Fade arithmetic:
  - fade_level all-ones returns c exactly.
  - fade_level 0 returns 0 for every c < 2^CH_W.
- Read/write to the same entry in the same cycle: the read returns the old value (read-before-write). A read on the cycle after the write returns the new value.
- When out_valid = 0, red/green/blue/out_transparent hold their last values. The bench must not check them while out_valid = 0.
- Transparency is flagged regardless of stored colour or fade.
- Out-of-range bank values cannot occur, since NUM_BANKS is a power of two.

Test Plan:
- Reset release: after Reset_n rises, init_done = 0 for 64 cycles, then 1. Stimulus rd_valid during INIT -> out_valid stays 0. First RUN read of bank 2 idx 7 -> RGB 0,0,0.
- Write/read: write bank 1 idx 3 = {D,9,7}; read bank1/idx3 with fade_level F next cycle -> 2 cycles later out_valid=1, red=D, green=9, blue=7, out_transparent=0.
- Fade: same entry at fade_level 7 -> red=(13*8)>>4=6, green=4, blue=3. At fade_level 0 -> 0,0,0.
- Bank isolation and transparency: write bank0 idx0 = {E,A,9} and bank3 idx0 = {1,0,0}; back-to-back reads of both -> consecutive out_valid cycles with the correct colours, out_transparent=1 on both.
- Read/write collision: entry holds {3,4,3}; write {5,6,6} and read the same entry in the same cycle -> output {3,4,3}; a read next cycle -> {5,6,6}.
- Mid-operation reset: pulse Reset_n low during a read stream in RUN -> outputs 0 immediately, init_done = 0, 64-cycle clear repeats, and previously written entries read back 0.
